simon_req_scheduler: RTL
========================

// Module: simon_req_scheduler
// PURPOSE
//  Shares one SIMON cipher core (controlBLK + round + key expansion) between NREQ requesters.
//  Arbitrates round-robin and drives the core's newDATA/newKEY/readDATA handshake.
//  Caches the last key loaded into the core, so key expansion is skipped while the key is unchanged.
//  Returns each result, with an error flag, to the requester that issued it.
// PARAMETERS
//  N        16    cipher word width in bits (block = 2*N)
//  M        4     key words (key = M*N)
//  NREQ     2     number of requesters, >=2
//  TIMEOUT  255   max cycles from issue to core doneDATA before abort
// PORTS
//  clk          in   1           clock; all logic on posedge
//  R            in   1           asynchronous active-high reset
//  req_valid    in   NREQ        per-requester request; held with payload until req_ready
//  req_enc_dec  in   NREQ        1=encrypt, 0=decrypt
//  req_data     in   NREQ*2*N    block per requester; slice k = [k*2N +: 2N]
//  req_key      in   NREQ*M*N    key per requester; slice k = [k*MN +: MN]
//  req_ready    out  NREQ        one-cycle accept pulse, one-hot
//  resp_valid   out  NREQ        result valid, one-hot; held until resp_ready
//  resp_ready   in   NREQ        requester consumes result
//  resp_data    out  2*N         result block (0 on error)
//  resp_err     out  1           1 = timeout abort
//  key_flush    in   1           invalidate key cache
//  newDATA      out  1           to core
//  newKEY       out  1           to core
//  readDATA     out  1           to core
//  enc_dec      out  1           to core
//  inDATA       out  2*N         to core
//  KEY          out  M*N         to core
//  loadDATA     in   1           from core; high once the block has been taken
//  loadKEY      in   1           from core; high once the key has been taken
//  doneDATA     in   1           from core; result ready on outDATA
//  outDATA      in   2*N         from core
// BEHAVIOUR
//  Reset (R=1, async)
//   - All outputs 0; state IDLE; rr_ptr=0; key_valid=0; cached key=0; timer=0.
//   - Reset mid-operation abandons the transaction and returns no response.
//  FSM states: IDLE -> ISSUE -> WAIT_DONE -> RESP -> IDLE.
//  IDLE
//   - Pick the first requester with req_valid=1, searching from rr_ptr upward modulo NREQ.
//   - Same edge: pulse req_ready[g]; latch g, data, key and enc_dec into registers.
//   - Same edge: hit = key_valid && (key==cache); go to ISSUE.
//  ISSUE
//   - Drive inDATA, KEY and enc_dec from the latched registers.
//   - newDATA=1; newKEY=~hit.
//   - Each strobe drops the cycle after the matching load (loadDATA / loadKEY) is seen high.
//   - On loadKEY: cache <= KEY; key_valid <= 1.
//   - Once every issued strobe has been acknowledged, go to WAIT_DONE.
//  WAIT_DONE
//   - On doneDATA=1: resp_data <= outDATA; readDATA=1 for exactly one cycle; go to RESP.
//  Timer
//   - Cleared on leaving IDLE; increments in ISSUE and WAIT_DONE.
//   - At TIMEOUT: drop all core strobes; resp_err=1; resp_data=0; key_valid=0; go to RESP.
//  RESP
//   - resp_valid[g]=1, with resp_data/resp_err stable, until resp_ready[g]=1.
//   - On that edge: clear resp_valid; rr_ptr <= (g+1) mod NREQ; go to IDLE.
//   - The next accept is one cycle later at the earliest.
//  Edge cases
//   - Exactly one transaction is in flight; req_valid is ignored outside IDLE.
//   - resp_ready on a non-granted lane is ignored.
//   - key_flush: key_valid <= 0 on any cycle.
//   - key_flush and loadKEY on the same edge: flush wins (key_valid=0).
//   - A decrypt miss still issues newKEY; the core holds the data until doneKEY.
//  Latency
//   - Accept -> newDATA: 1 cycle.
//   - doneDATA -> resp_valid: 1 cycle.
//  Widths: key compare is the full M*N bits; timer is clog2(TIMEOUT+1) bits and saturates.
// TESTING
//  1. Reset with req_valid=2'b11 held -> all outputs 0; after release req_ready=2'b01 first.
//  2. Req0 encrypts pt 0x6565_6877, key 0x1918_1110_0908_0100 -> newKEY=1 issued;
//     resp_data=0xc69b_e9bb, resp_err=0.
//  3. Req0 repeats with the same key -> newKEY stays 0; same ciphertext.
//     Then key_flush=1 and repeat -> newKEY=1.
//  4. Both requesters valid back-to-back, 3 rounds each -> grant order 0,1,0,1,0,1.
//     No lane starved; one-hot req_ready/resp_valid throughout.
//  5. Decrypt 0xc69b_e9bb with the cached key -> resp_data=0x6565_6877.
//  6. Core model never asserts doneDATA -> after TIMEOUT cycles resp_err=1, resp_data=0.
//     Next request re-issues newKEY.
//  7. R asserted in WAIT_DONE -> immediate IDLE, outputs 0, no response, rr_ptr=0.

Source files
------------

// File: rtl/simon_req_scheduler.sv
// Round-robin front end that shares one SIMON core between NREQ requesters.
// Keeps the last key loaded into the core so repeated keys skip key expansion.
module simon_req_scheduler #(
    parameter int N       = 16,
    parameter int M       = 4,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  R,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_enc_dec,
    input  logic [NREQ*2*N-1:0]   req_data,
    input  logic [NREQ*M*N-1:0]   req_key,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [2*N-1:0]        resp_data,
    output logic                  resp_err,
    input  logic                  key_flush,
    output logic                  newDATA,
    output logic                  newKEY,
    output logic                  readDATA,
    output logic                  enc_dec,
    output logic [2*N-1:0]        inDATA,
    output logic [M*N-1:0]        KEY,
    input  logic                  loadDATA,
    input  logic                  loadKEY,
    input  logic                  doneDATA,
    input  logic [2*N-1:0]        outDATA
);
    localparam int BW = 2 * N;
    localparam int KW = M * N;
    localparam int GW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t          state_r;
    logic [GW-1:0]   rr_ptr_r;
    logic [GW-1:0]   grant_r;
    logic [KW-1:0]   cache_r;
    logic            key_valid_r;
    logic [TW-1:0]   timer_r;

    logic            pick_found_s;
    logic [GW-1:0]   pick_idx_s;
    logic [BW-1:0]   sel_data_s;
    logic [KW-1:0]   sel_key_s;
    logic            sel_enc_s;
    logic            hit_s;
    logic            data_pend_s;
    logic            key_pend_s;
    logic            timeout_s;
    logic [NREQ-1:0] pick_oh_s;
    logic [NREQ-1:0] grant_oh_s;
    logic [GW-1:0]   rr_next_s;

    // First requesting lane at or above the round-robin pointer, wrapping modulo NREQ.
    always_comb begin
        int cand;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        sel_data_s   = '0;
        sel_key_s    = '0;
        sel_enc_s    = 1'b0;
        cand         = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(rr_ptr_r) + i;
            cand = (cand >= NREQ) ? cand - NREQ : cand;
            if (!pick_found_s && req_valid[cand]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = GW'(cand);
                sel_data_s   = req_data[cand*BW +: BW];
                sel_key_s    = req_key[cand*KW +: KW];
                sel_enc_s    = req_enc_dec[cand];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // A flush on the accept edge must not let a stale cache entry count as a hit.
    assign hit_s       = key_valid_r && !key_flush && (sel_key_s == cache_r);
    assign data_pend_s = newDATA && !loadDATA;
    assign key_pend_s  = newKEY && !loadKEY;
    assign timeout_s   = (timer_r == TW'(TIMEOUT));
    assign pick_oh_s   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
    assign grant_oh_s  = {{(NREQ-1){1'b0}}, 1'b1} << grant_r;
    assign rr_next_s   = (grant_r == GW'(NREQ - 1)) ? '0 : grant_r + GW'(1);

    // Transaction FSM: accept, core handshake, timeout abort and response hold.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_r     <= IDLE;
            rr_ptr_r    <= '0;
            grant_r     <= '0;
            cache_r     <= '0;
            key_valid_r <= 1'b0;
            timer_r     <= '0;
            req_ready   <= '0;
            resp_valid  <= '0;
            resp_data   <= '0;
            resp_err    <= 1'b0;
            newDATA     <= 1'b0;
            newKEY      <= 1'b0;
            readDATA    <= 1'b0;
            enc_dec     <= 1'b0;
            inDATA      <= '0;
            KEY         <= '0;
        end else begin
            req_ready <= '0;
            if (key_flush) begin
                key_valid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (pick_found_s) begin
                        req_ready <= pick_oh_s;
                        grant_r   <= pick_idx_s;
                        inDATA    <= sel_data_s;
                        KEY       <= sel_key_s;
                        enc_dec   <= sel_enc_s;
                        newDATA   <= 1'b1;
                        newKEY    <= ~hit_s;
                        timer_r   <= '0;
                        state_r   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (timeout_s) begin
                        newDATA     <= 1'b0;
                        newKEY      <= 1'b0;
                        resp_err    <= 1'b1;
                        resp_data   <= '0;
                        key_valid_r <= 1'b0;
                        resp_valid  <= grant_oh_s;
                        state_r     <= RESP;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                        if (loadDATA) begin
                            newDATA <= 1'b0;
                        end
                        if (newKEY && loadKEY) begin
                            newKEY      <= 1'b0;
                            cache_r     <= KEY;
                            key_valid_r <= ~key_flush;
                        end
                        if (!data_pend_s && !key_pend_s) begin
                            state_r <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (doneDATA) begin
                        resp_data  <= outDATA;
                        readDATA   <= 1'b1;
                        resp_valid <= grant_oh_s;
                        state_r    <= RESP;
                    end else if (timeout_s) begin
                        resp_err    <= 1'b1;
                        resp_data   <= '0;
                        key_valid_r <= 1'b0;
                        resp_valid  <= grant_oh_s;
                        state_r     <= RESP;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                RESP: begin
                    readDATA <= 1'b0;
                    if (resp_ready[grant_r]) begin
                        resp_valid <= '0;
                        resp_data  <= '0;
                        resp_err   <= 1'b0;
                        rr_ptr_r   <= rr_next_s;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    newDATA    <= 1'b0;
                    newKEY     <= 1'b0;
                    readDATA   <= 1'b0;
                    resp_valid <= '0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end
endmodule
